tmr_dev: RTL and testbench
==========================

# tmr_dev

Interval timer peripheral for the XM23 CPU's memory-mapped device space. It sits beside the keyboard/screen driver and feeds the CPU's device-memory bus mux. The CPU reads `tmr_csr` (device byte 4) from `csr_o` and `tmr_data` (device byte 5) from `data_o`; CPU writes to those addresses arrive on the strobe inputs. The block prescales `Clock`, counts ticks up to a programmed period, and reports each expiry through the standard XM23 CSR flags (DBA, OF) plus an interrupt request.

## Interface
- `PRESCALE`, default 50000: `Clock` cycles per timer tick. Legal range 1..65535.
- `Clock`  in  1  system clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `csr_wr`  in  1  CPU write strobe for `tmr_csr`, one cycle.
- `csr_wdata`  in  8  data written to `tmr_csr`.
- `csr_rd`  in  1  CPU read strobe for `tmr_csr`, one cycle; clears the flags.
- `data_wr`  in  1  CPU write strobe for `tmr_data`; loads the period.
- `data_wdata`  in  8  new period value.
- `csr_o`  out  8  CSR image.
- `data_o`  out  8  current tick count.
- `irq`  out  1  interrupt request, `IE & DBA`.

## Operation
- CSR bit map:
  - bit0 IE, writable.
  - bit1 I/O, constant 0.
  - bit2 DBA, read-only.
  - bit3 OF, read-only.
  - bit4 ENA, writable.
  - bits 7:5, constant 0.
- `csr_wr` updates only IE and ENA. Writes to DBA, OF and reserved bits are ignored.
- Internal registers:
  - `presc`: 16-bit, counts 0..PRESCALE-1.
  - `count`: 8-bit.
  - `period`: 8-bit.
- States, held in one register:
  - IDLE: ENA=0, or ENA=1 with period=0.
  - RUN: ENA=1 and period≠0.
- IDLE: `presc` and `count` hold their values and no events occur.
- RUN: `presc` increments each cycle. At PRESCALE-1 it wraps to 0 and generates a tick.
- Tick behaviour:
  - `count`+1 < period: `count` increments.
  - Otherwise: `count` wraps to 0 and an expiry event fires.
- Expiry event: if DBA=0, set DBA. If DBA=1, set OF; DBA stays 1.
- `csr_rd` clears DBA and OF on that edge.
- ENA 0→1 transition via `csr_wr`: clears `presc` and `count`; DBA and OF are unchanged.
- ENA 1→0: freezes `presc` and `count`.
- `data_wr` loads `period` and clears `presc` and `count`. Writing 0 forces IDLE. A nonzero value with ENA=1 enters RUN.
- Simultaneous events:
  - `csr_rd` and expiry on the same edge: the read's clear applies first, then the expiry. Result: DBA=1, OF=0.
  - `csr_wr` and expiry on the same edge: the expiry is still recorded. IE and ENA take the written value.
  - `data_wr` and tick on the same edge: `data_wr` wins; `count`=0 and no event.
  - `data_wr` and `csr_wr` on the same edge: both apply. Clearing is identical, so the order is irrelevant.
- `irq` is combinational from the registered IE and DBA; no other inputs feed it.
- Reset mid-count aborts with no event. All registers return to reset values.

## Timing
- Reset values: `csr_o`=8'h00, `data_o`=8'h00, `irq`=0, `period`=0, `presc`=0, state=IDLE.
- Strobes are sampled on the rising edge. Effects are visible on outputs immediately after that edge.
- Register-to-output latency is 0 cycles; `csr_o` and `data_o` are driven directly from registers.
- Let E be the edge on which ENA rises, or on which `data_wr` loads a period while ENA=1.
  - Ticks occur at E+PRESCALE·k.
  - First expiry, with DBA visible, is at edge E+PRESCALE·period.
  - Later expiries are every PRESCALE·period cycles.
- `irq` asserts in the same cycle DBA sets (with IE=1). It deasserts the cycle after a `csr_rd` edge, unless the same-edge expiry rule applies.
- Arithmetic wrap rules:
  - `count` never exceeds period-1.
  - period=255 gives 255 ticks per expiry.
  - PRESCALE=1 ticks every cycle.

## Test plan
- Reset and idle: assert `Reset` asynchronously mid-cycle -> `csr_o`=00, `data_o`=00, `irq`=0 immediately. Run 100 cycles with no strobes -> outputs stay 0.
- Basic expiry (PRESCALE=4): `data_wr` with 3, then `csr_wr` with 8'h11 at edge E -> `data_o` reads 1, 2 at E+4, E+8; at E+12, `data_o`=0, `csr_o`=8'h15, `irq`=1.
- Overflow and clear: continue the previous run without reading -> at E+24, `csr_o`=8'h1D. `csr_rd` -> next cycle `csr_o`=8'h11, `irq`=0.
- Read/expiry collision: pulse `csr_rd` exactly at E+36 while OF=1 -> `csr_o`=8'h15 after that edge (DBA=1, OF=0).
- Period and enable edge cases:
  - `data_wr` with 0 while running -> counting stops and no DBA for 1000 cycles.
  - `csr_wr` with 8'h01 (ENA=0) -> `data_o` frozen.
  - Writing 8'hFF to the CSR -> `csr_o` bits 1, 5-7 stay 0.
- Tick/write collision: `data_wr` with 5 on a tick edge -> `data_o`=0 and no event. Next expiry occurs 5·PRESCALE cycles later.

Source files
------------

// File: rtl/tmr_dev.sv
// tmr_dev: XM23 interval timer. It divides Clock by PRESCALE to make ticks,
// counts ticks up to a programmed period, and raises DBA/OF and irq on
// each expiry.
module tmr_dev #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       csr_wr,
  input  logic [7:0] csr_wdata,
  input  logic       csr_rd,
  input  logic       data_wr,
  input  logic [7:0] data_wdata,
  output logic [7:0] csr_o,
  output logic [7:0] data_o,
  output logic       irq
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  period_q, period_d;
  logic        ie_q, ie_d;
  logic        ena_q, ena_d;
  logic        dba_q, dba_d;
  logic        of_q, of_d;
  logic        tick, expire;

  // Only IE and ENA are writable; the other CSR write bits are dropped.
  logic unused_wdata;
  assign unused_wdata = ^{csr_wdata[7:5], csr_wdata[3:1]};

  // Next-state logic. Priority order matters: a read clears the flags
  // before a same-edge expiry is recorded, and a period load overrides a
  // same-edge tick.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    count_d  = count_q;
    period_d = period_q;
    ie_d     = ie_q;
    ena_d    = ena_q;
    dba_d    = dba_q;
    of_d     = of_q;
    expire   = 1'b0;

    tick = (state_q == RUN) && !data_wr && (presc_q == PRESC_MAX);

    if (state_q == RUN)
      presc_d = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;

    if (tick) begin
      if (({1'b0, count_q} + 9'd1) < {1'b0, period_q}) begin
        count_d = count_q + 8'd1;
      end else begin
        count_d = 8'd0;
        expire  = 1'b1;
      end
    end

    if (csr_rd) begin
      dba_d = 1'b0;
      of_d  = 1'b0;
    end
    if (expire) begin
      if (dba_d) of_d  = 1'b1;
      else       dba_d = 1'b1;
    end

    if (csr_wr) begin
      ie_d  = csr_wdata[0];
      ena_d = csr_wdata[4];
      // Enabling restarts the interval from a clean prescaler.
      if (csr_wdata[4] && !ena_q) begin
        presc_d = 16'd0;
        count_d = 8'd0;
      end
    end

    if (data_wr) begin
      period_d = data_wdata;
      presc_d  = 16'd0;
      count_d  = 8'd0;
    end

    state_d = (ena_d && (period_d != 8'd0)) ? RUN : IDLE;
  end

  // State and register update; reset aborts any interval in progress.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      presc_q  <= 16'd0;
      count_q  <= 8'd0;
      period_q <= 8'd0;
      ie_q     <= 1'b0;
      ena_q    <= 1'b0;
      dba_q    <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      period_q <= period_d;
      ie_q     <= ie_d;
      ena_q    <= ena_d;
      dba_q    <= dba_d;
      of_q     <= of_d;
    end
  end

  assign csr_o  = {3'b000, ena_q, of_q, dba_q, 1'b0, ie_q};
  assign data_o = count_q;
  assign irq    = ie_q & dba_q;

endmodule

// File: tb/tb_tmr_dev.sv
// tb_tmr_dev: directed and random checks of tmr_dev against an elapsed-time
// model of the timer (PRESCALE=4).
module tb_tmr_dev;

  localparam int P = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       csr_wr = 1'b0;
  logic [7:0] csr_wdata = 8'h00;
  logic       csr_rd = 1'b0;
  logic       data_wr = 1'b0;
  logic [7:0] data_wdata = 8'h00;
  logic [7:0] csr_o;
  logic [7:0] data_o;
  logic       irq;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: cycles elapsed in the current interval, modulo PRESCALE*period.
  bit m_ie, m_ena, m_dba, m_of;
  int m_period, m_el;

  tmr_dev #(.PRESCALE(P)) dut (
    .Clock(Clock), .Reset(Reset),
    .csr_wr(csr_wr), .csr_wdata(csr_wdata), .csr_rd(csr_rd),
    .data_wr(data_wr), .data_wdata(data_wdata),
    .csr_o(csr_o), .data_o(data_o), .irq(irq)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    m_ie = 0; m_ena = 0; m_dba = 0; m_of = 0; m_period = 0; m_el = 0;
  endtask

  task automatic model_edge(input bit cw, input logic [7:0] cwd, input bit cr,
                            input bit dw, input logic [7:0] dwd);
    bit adv, ev;
    adv = m_ena && (m_period != 0) && !dw;
    ev  = adv && (((m_el + 1) % (P * m_period)) == 0);
    if (cr) begin m_dba = 0; m_of = 0; end
    if (ev) begin
      if (m_dba) m_of = 1; else m_dba = 1;
    end
    if (adv) m_el = (m_el + 1) % (P * m_period);
    if (cw) begin
      if (cwd[4] && !m_ena) m_el = 0;
      m_ie = cwd[0]; m_ena = cwd[4];
    end
    if (dw) begin m_period = int'(dwd); m_el = 0; end
  endtask

  function automatic logic [7:0] exp_csr();
    return {3'b000, m_ena, m_of, m_dba, 1'b0, m_ie};
  endfunction

  function automatic logic [7:0] exp_data();
    return (m_period == 0) ? 8'd0 : 8'(m_el / P);
  endfunction

  // One clock edge with the given strobes; returns at edge+1.
  task automatic step(input bit cw, input logic [7:0] cwd, input bit cr,
                      input bit dw, input logic [7:0] dwd);
    csr_wr = cw; csr_wdata = cwd; csr_rd = cr; data_wr = dw; data_wdata = dwd;
    @(posedge Clock);
    model_edge(cw, cwd, cr, dw, dwd);
    #1;
    csr_wr = 0; csr_rd = 0; data_wr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    @(posedge Clock); #1;
    Reset = 0;
    model_reset();
    n_chk++; if (csr_o !== 8'h00) $display("FAIL reset_csr got %h want 00", csr_o); else n_pass++;
    n_chk++; if (data_o !== 8'h00) $display("FAIL reset_data got %h want 00", data_o); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
    step(1, 8'h11, 0, 0, 8'h00);
    step(0, 8'h00, 0, 1, 8'h01);
    idle(6);
    n_chk++; if (csr_o !== exp_csr()) $display("FAIL pre_reset_csr got %h want %h", csr_o, exp_csr()); else n_pass++;
    // Asynchronous assertion between clock edges.
    #3 Reset = 1;
    #1;
    model_reset();
    n_chk++; if ({csr_o, data_o, irq} !== 17'd0)
      $display("FAIL async_reset got csr=%h data=%h irq=%b want 00/00/0", csr_o, data_o, irq); else n_pass++;
    @(posedge Clock); #1;
    Reset = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 8'h00, 0, 0, 8'h00);
      n_chk++; if ({csr_o, data_o, irq} !== 17'd0)
        $display("FAIL idle_cyc%0d got csr=%h data=%h irq=%b want zeros", i, csr_o, data_o, irq); else n_pass++;
    end
  endtask

  task automatic test_basic_expiry();
    step(0, 8'h00, 0, 1, 8'h03);
    step(1, 8'h11, 0, 0, 8'h00);  // edge E
    n_chk++; if (data_o !== 8'd0) $display("FAIL basic_E_data got %h want 00", data_o); else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      step(0, 8'h00, 0, 0, 8'h00);
      if (k == 4) begin
        n_chk++; if (data_o !== 8'd1) $display("FAIL basic_E4_data got %h want 01", data_o); else n_pass++;
      end
      if (k == 8) begin
        n_chk++; if (data_o !== 8'd2) $display("FAIL basic_E8_data got %h want 02", data_o); else n_pass++;
      end
      n_chk++; if ({csr_o, data_o} !== {exp_csr(), exp_data()})
        $display("FAIL basic_model_k%0d got %h/%h want %h/%h", k, csr_o, data_o, exp_csr(), exp_data()); else n_pass++;
    end
    n_chk++; if ({csr_o, data_o, irq} !== {8'h15, 8'h00, 1'b1})
      $display("FAIL basic_E12 got csr=%h data=%h irq=%b want 15/00/1", csr_o, data_o, irq); else n_pass++;
  endtask

  task automatic test_overflow_clear();
    idle(12);  // E+24
    n_chk++; if (csr_o !== 8'h1D) $display("FAIL overflow_csr got %h want 1d", csr_o); else n_pass++;
    n_chk++; if (irq !== 1'b1) $display("FAIL overflow_irq got %b want 1", irq); else n_pass++;
  endtask

  task automatic test_read_collision();
    idle(11);                      // E+35, OF still 1
    step(0, 8'h00, 1, 0, 8'h00);   // read on expiry edge E+36
    n_chk++; if (csr_o !== 8'h15) $display("FAIL rd_collision_csr got %h want 15", csr_o); else n_pass++;
    n_chk++; if (irq !== 1'b1) $display("FAIL rd_collision_irq got %b want 1", irq); else n_pass++;
    step(0, 8'h00, 1, 0, 8'h00);
    n_chk++; if (csr_o !== 8'h11) $display("FAIL rd_clear_csr got %h want 11", csr_o); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL rd_clear_irq got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_edge_cases();
    logic [7:0] frozen;
    int bad;
    step(0, 8'h00, 0, 1, 8'h00);   // period 0 while running
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 8'h00, 0, 0, 8'h00);
      if (csr_o[2] !== 1'b0 || data_o !== 8'd0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL period0_stop got %0d bad cycles want 0", bad); else n_pass++;
    step(0, 8'h00, 0, 1, 8'h03);
    idle(6);
    step(1, 8'h01, 0, 0, 8'h00);   // ENA off
    frozen = data_o;
    n_chk++; if (frozen !== exp_data()) $display("FAIL freeze_start got %h want %h", frozen, exp_data()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(0, 8'h00, 0, 0, 8'h00);
      if (data_o !== frozen) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL freeze_hold got %0d changed cycles want 0", bad); else n_pass++;
    step(1, 8'hFF, 0, 0, 8'h00);
    n_chk++; if ((csr_o & 8'hE2) !== 8'h00) $display("FAIL csr_const_bits got %h want bits 1,7:5 zero", csr_o); else n_pass++;
    n_chk++; if (csr_o !== exp_csr()) $display("FAIL csr_ff got %h want %h", csr_o, exp_csr()); else n_pass++;
    n_chk++; if (data_o !== 8'd0) $display("FAIL ena_rise_clear got %h want 00", data_o); else n_pass++;
  endtask

  task automatic test_tick_write();
    idle(7);
    step(0, 8'h00, 0, 1, 8'h05);   // lands on a tick edge
    n_chk++; if ({data_o, csr_o[2]} !== {8'h00, 1'b0})
      $display("FAIL tick_write got data=%h dba=%b want 00/0", data_o, csr_o[2]); else n_pass++;
    idle(5 * P - 1);
    n_chk++; if (csr_o[2] !== 1'b0) $display("FAIL tick_write_early got dba=%b want 0", csr_o[2]); else n_pass++;
    idle(1);
    n_chk++; if ({csr_o[2], data_o} !== {1'b1, 8'h00})
      $display("FAIL tick_write_expiry got dba=%b data=%h want 1/00", csr_o[2], data_o); else n_pass++;
  endtask

  task automatic test_random();
    bit cw, cr, dw;
    logic [7:0] cwd, dwd;
    for (int i = 0; i < 3000; i++) begin
      cw  = ($urandom_range(0, 15) == 0);
      cr  = ($urandom_range(0, 7) == 0);
      dw  = ($urandom_range(0, 31) == 0);
      cwd = 8'($urandom);
      dwd = 8'($urandom_range(0, 6));
      step(cw, cwd, cr, dw, dwd);
      n_chk++; if ({csr_o, data_o, irq} !== {exp_csr(), exp_data(), m_ie & m_dba})
        $display("FAIL random_cyc%0d got %h/%h/%b want %h/%h/%b", i, csr_o, data_o, irq,
                 exp_csr(), exp_data(), m_ie & m_dba); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_expiry();
    test_overflow_clear();
    test_read_collision();
    test_edge_cases();
    test_tick_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
